// File: rtl/gcd_binary_w_if.sv
// gcd_binary_w_if: start/a/b request and result/result_ready/busy response bundle for gcd_binary_w
interface gcd_binary_w_if #(parameter int W = 18);
  logic start;
  logic [W-1:0] a, b, result;
  logic result_ready, busy;
  modport master(output start, a, b, input result, result_ready, busy);
  modport slave(input start, a, b, output result, result_ready, busy);
endinterface

// File: rtl/gcd_binary_w.sv
// gcd_binary_w: binary (Stein) GCD engine; ports clk, reset, bus (slave: start,a,b -> result,result_ready,busy), cycles only with GCD_CYCLE_COUNT_EN
module gcd_binary_w #(
  parameter int W = 18
`ifdef GCD_CYCLE_COUNT_EN
  , parameter int CW = 8
`endif
) (
  input logic clk,
  input logic reset,
  gcd_binary_w_if.slave bus
`ifdef GCD_CYCLE_COUNT_EN
  , output logic [CW-1:0] cycles
`endif
);
  localparam int KW = $clog2(W + 1);
  typedef enum logic [1:0] {ST_READY, ST_STRIP, ST_REDUCE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r, a_n, b_n, res_r, res_n;
  logic [KW-1:0] k, k_n;
  always_comb begin
    state_n = state;
    a_n = a_r;
    b_n = b_r;
    k_n = k;
    res_n = res_r;
    if (state != ST_READY) begin
      if (a_r == '0) begin
        res_n = b_r << k;
        state_n = ST_READY;
      end else if (b_r == '0) begin
        res_n = a_r << k;
        state_n = ST_READY;
      end else if (state == ST_STRIP) begin
        if (!a_r[0] && !b_r[0]) begin
          a_n = a_r >> 1;
          b_n = b_r >> 1;
          k_n = k + 1'b1;
        end else state_n = ST_REDUCE;
      end else if (!a_r[0]) a_n = a_r >> 1;
      else if (!b_r[0]) b_n = b_r >> 1;
      else if (a_r >= b_r) a_n = (a_r - b_r) >> 1;
      else b_n = (b_r - a_r) >> 1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_READY;
      res_r <= '0;
      k <= '0;
      a_r <= '0;
      b_r <= '0;
    end else if (bus.start) begin
      state <= ST_STRIP;
      a_r <= bus.a;
      b_r <= bus.b;
      k <= '0;
    end else begin
      state <= state_n;
      a_r <= a_n;
      b_r <= b_n;
      k <= k_n;
      res_r <= res_n;
    end
  end
`ifdef GCD_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || bus.start) cycles <= '0;
    else if (state != ST_READY && cycles != '1) cycles <= cycles + 1'b1;
  end
`endif
  assign bus.result = res_r;
  assign bus.busy = state != ST_READY;
  assign bus.result_ready = (state == ST_READY) && !bus.start;
endmodule

// File: tb/tb_gcd_binary_w.sv
// tb_gcd_binary_w: scoreboard bench for gcd_binary_w with directed and random operand pairs
module tb_gcd_binary_w;
  localparam int W = 18;
  logic clk = 1'b0;
  logic reset = 1'b1;
  gcd_binary_w_if #(.W(W)) bus();
`ifdef GCD_CYCLE_COUNT_EN
  logic [7:0] cycles;
`endif
  gcd_binary_w #(
    .W(W)
`ifdef GCD_CYCLE_COUNT_EN
    , .CW(8)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef GCD_CYCLE_COUNT_EN
    , .cycles(cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] res;
    int start_cyc;
    int lat;
    bit abort;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int mon_lat;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic prev_busy = 1'b0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] res, input int lat);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    q.push_back('{res, cyc + 1, lat, 1'b0});
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    chk("done_timeout", bus.busy, 0);
  endtask
  always @(negedge clk) begin
    if (cyc > 2) chk("ready_rule", bus.result_ready, !bus.busy && !bus.start);
    if (prev_busy && !bus.busy) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none", bus.result);
      end else begin
        mon_e = q.pop_front();
        mon_lat = cyc - mon_e.start_cyc;
        chk("result", bus.result, mon_e.res);
        if (!mon_e.abort) begin
          if (mon_e.lat >= 0) chk("latency", mon_lat, mon_e.lat);
          else chk("latency_bound", mon_lat <= 56, 1);
        end
`ifdef GCD_CYCLE_COUNT_EN
        chk("cycles", cycles, mon_e.abort ? 0 : mon_lat);
`endif
      end
    end
    prev_busy = bus.busy;
  end
  logic [W-1:0] da [6] = '{12, 0, 0, 17, 131072, 7};
  logic [W-1:0] db [6] = '{18, 7, 0, 17, 131072, 0};
  logic [W-1:0] dr [6] = '{6, 7, 0, 17, 131072, 7};
  int dl [6] = '{6, 1, 1, 3, 20, 1};
  initial begin
    logic [W-1:0] x, y;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_result", bus.result, 0);
    chk("reset_ready", bus.result_ready, 1);
    chk("reset_busy", bus.busy, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("reset_cycles", cycles, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      issue(da[i], db[i], dr[i], dl[i]);
      wait_idle();
    end
    issue(12, 18, 6, 6);
    wait_idle();
    issue(12, 18, 6, 6);
    @(posedge clk);
    #1 chk("hold_busy", bus.busy, 1);
    chk("hold_result", bus.result, 6);
    bus.a = 35;
    bus.b = 14;
    bus.start = 1'b1;
    void'(q.pop_back());
    q.push_back('{18'd7, cyc + 1, 6, 1'b0});
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("restart_hold_result", bus.result, 6);
    wait_idle();
    issue(12, 18, 6, 6);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 q.delete();
    q.push_back('{'0, 0, 0, 1'b1});
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort_result", bus.result, 0);
    chk("abort_ready", bus.result_ready, 1);
    chk("abort_busy", bus.busy, 0);
    for (int i = 0; i < 1000; i++) begin
      x = W'($urandom() >> $urandom_range(14, 31));
      y = W'($urandom() >> $urandom_range(14, 31));
      issue(x, y, ref_gcd(x, y), -1);
      wait_idle();
    end
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
